// File: rtl/lcd_pixel_fifo.sv
// lcd_pixel_fifo: single-clock pixel FIFO that feeds lcd_rgb_top's data_in/data_req handshake.
// It locks the camera stream to the LCD frame: after each out_vsync rise it flushes and then
// waits for a wr_sof write before accepting pixels. While it has no pixel to give, it serves
// FILL_COLOR.
// Ports:
//   lcd_clk, sys_rst_n          clock and asynchronous active-low reset
//   wr_en, wr_data, wr_sof      camera-side write, with a first-pixel-of-frame qualifier
//   out_vsync                   LCD frame sync; a rising edge flushes the FIFO
//   data_req, data_in           pixel request, and the registered pixel one cycle later
//   empty, full, almost_full    registered occupancy flags
//   level                       registered occupancy
//   overflow, underflow         sticky per-frame error flags
// Optional build macro LCD_PIXEL_FIFO_STAT_EN adds the saturating counters ovf_cnt and udf_cnt.
module lcd_pixel_fifo #(
  parameter int unsigned     DEPTH      = 1024,
  parameter int unsigned     DW         = 16,
  parameter logic [DW-1:0]   FILL_COLOR = '0,
  parameter int unsigned     AFULL_TH   = DEPTH - 16
) (
  input  logic                   lcd_clk,
  input  logic                   sys_rst_n,
  input  logic                   wr_en,
  input  logic [DW-1:0]          wr_data,
  input  logic                   wr_sof,
  input  logic                   out_vsync,
  input  logic                   data_req,
  output logic [DW-1:0]          data_in,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   underflow
`ifdef LCD_PIXEL_FIFO_STAT_EN
  ,
  output logic [15:0]            ovf_cnt,
  output logic [15:0]            udf_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic {WAIT_SOF, STREAM} state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wptr, wptr_nxt, rptr, rptr_nxt, wr_addr;
  logic [LW-1:0]   level_nxt;
  logic [DW-1:0]   data_in_nxt;
  logic            vsync_d, vs_edge, pop, wr_gate, wr_acc, wr_drop, fill_srv;
  logic            ovf_nxt, udf_nxt;

  // Next-state logic: a frame-sync edge flushes everything, then a coincident SOF write is stored.
  always_comb begin
    state_nxt   = state;
    wptr_nxt    = wptr;
    rptr_nxt    = rptr;
    level_nxt   = level;
    data_in_nxt = data_in;
    ovf_nxt     = overflow;
    udf_nxt     = underflow;
    pop         = 1'b0;
    wr_acc      = 1'b0;
    wr_drop     = 1'b0;
    fill_srv    = 1'b0;
    wr_addr     = wptr;
    vs_edge     = out_vsync & ~vsync_d;
    wr_gate     = wr_en && (state == STREAM || wr_sof);
    if (vs_edge) begin
      state_nxt = WAIT_SOF;
      rptr_nxt  = '0;
      wptr_nxt  = '0;
      level_nxt = '0;
      ovf_nxt   = 1'b0;
      udf_nxt   = 1'b0;
      wr_addr   = '0;
      if (data_req) data_in_nxt = FILL_COLOR;
      if (wr_en && wr_sof) begin
        wr_acc    = 1'b1;
        state_nxt = STREAM;
        wptr_nxt  = AW'(1);
        level_nxt = LW'(1);
      end
    end else begin
      pop      = data_req && !empty && (state == STREAM);
      // A same-cycle pop frees a slot, so a write into a full FIFO is still accepted then.
      wr_acc   = wr_gate && (!full || pop);
      wr_drop  = wr_gate && full && !pop;
      fill_srv = data_req && !pop && (state == STREAM);
      if (data_req) data_in_nxt = pop ? mem[rptr] : FILL_COLOR;
      if (pop) rptr_nxt = rptr + AW'(1);
      if (wr_acc) begin
        wptr_nxt = wptr + AW'(1);
        if (wr_sof) state_nxt = STREAM;
      end
      if (wr_acc && !pop)      level_nxt = level + LW'(1);
      else if (pop && !wr_acc) level_nxt = level - LW'(1);
      if (wr_drop)  ovf_nxt = 1'b1;
      if (fill_srv) udf_nxt = 1'b1;
    end
  end

  // State, pointer and output registers.
  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= WAIT_SOF;
      vsync_d     <= 1'b0;
      wptr        <= '0;
      rptr        <= '0;
      level       <= '0;
      data_in     <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      state       <= state_nxt;
      vsync_d     <= out_vsync;
      wptr        <= wptr_nxt;
      rptr        <= rptr_nxt;
      level       <= level_nxt;
      data_in     <= data_in_nxt;
      empty       <= (level_nxt == '0);
      full        <= (level_nxt == LW'(DEPTH));
      almost_full <= (level_nxt >= LW'(AFULL_TH));
      overflow    <= ovf_nxt;
      underflow   <= udf_nxt;
    end
  end

  // Pixel storage; no reset, so it maps onto plain RAM.
  always_ff @(posedge lcd_clk) begin
    if (wr_acc) mem[wr_addr] <= wr_data;
  end

`ifdef LCD_PIXEL_FIFO_STAT_EN
  // Saturating per-frame drop and fill counters.
  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ovf_cnt <= '0;
      udf_cnt <= '0;
    end else if (vs_edge) begin
      ovf_cnt <= '0;
      udf_cnt <= '0;
    end else begin
      if (wr_drop && ovf_cnt != 16'hFFFF)  ovf_cnt <= ovf_cnt + 16'd1;
      if (fill_srv && udf_cnt != 16'hFFFF) udf_cnt <= udf_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lcd_pixel_fifo.sv
// Directed testbench for lcd_pixel_fifo. A queue model predicts the FIFO contents, and a
// scoreboard of expected pixels is checked one cycle after each request. The bench drives two
// instances from the same inputs: DEPTH=128, and DEPTH=16 for the pointer-wrap test.
module tb_lcd_pixel_fifo;

  localparam int unsigned D   = 128;
  localparam logic [15:0] FIL = 16'hF00D;

  logic clk = 1'b0;
  logic rst_n, wr_en, wr_sof, out_vsync, data_req;
  logic [15:0] wr_data;
  logic [15:0] data_in, data_in16;
  logic empty, full, almost_full, overflow, underflow;
  logic empty16, full16, afull16, ovf16, udf16;
  logic [7:0] level;
  logic [4:0] level16;
`ifdef LCD_PIXEL_FIFO_STAT_EN
  logic [15:0] ovf_cnt, udf_cnt, ovf_cnt16, udf_cnt16;
`endif

  always #5 clk = ~clk;

  lcd_pixel_fifo #(.DEPTH(D), .DW(16), .FILL_COLOR(FIL), .AFULL_TH(D - 16)) dut (
    .lcd_clk(clk), .sys_rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .wr_sof(wr_sof),
    .out_vsync(out_vsync), .data_req(data_req), .data_in(data_in), .empty(empty),
    .full(full), .almost_full(almost_full), .level(level), .overflow(overflow),
    .underflow(underflow)
`ifdef LCD_PIXEL_FIFO_STAT_EN
    , .ovf_cnt(ovf_cnt), .udf_cnt(udf_cnt)
`endif
  );

  lcd_pixel_fifo #(.DEPTH(16), .DW(16), .FILL_COLOR(FIL), .AFULL_TH(12)) dut16 (
    .lcd_clk(clk), .sys_rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .wr_sof(wr_sof),
    .out_vsync(out_vsync), .data_req(data_req), .data_in(data_in16), .empty(empty16),
    .full(full16), .almost_full(afull16), .level(level16), .overflow(ovf16),
    .underflow(udf16)
`ifdef LCD_PIXEL_FIFO_STAT_EN
    , .ovf_cnt(ovf_cnt16), .udf_cnt(udf_cnt16)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] mq[$];
  logic [15:0] exp_q[$];
  logic        m_stream, m_ovf, m_udf, m_vs_d, chk16;
  logic [15:0] m_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_stream = 1'b0;
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
    m_vs_d   = 1'b0;
    m_last   = 16'h0000;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; wr_sof = 1'b0; out_vsync = 1'b0; data_req = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data_in", 32'(data_in), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_afull", 32'(almost_full), 32'h0);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_udf", 32'(underflow), 32'h0);
    chk("rst_level16", 32'(level16), 32'h0);
    chk("rst_empty16", 32'(empty16), 32'h1);
    rst_n = 1'b1;
  endtask

  // One clock: drive inputs, advance the model and scoreboard, then check after the edge.
  task automatic cyc(input logic wen, input logic [15:0] wd, input logic sof,
                     input logic vs, input logic req);
    logic edg, pop, acc;
    logic [15:0] e;
    wr_en = wen; wr_data = wd; wr_sof = sof; out_vsync = vs; data_req = req;
    edg = vs && !m_vs_d;
    m_vs_d = vs;
    if (edg) begin
      mq.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_stream = 1'b0;
      if (req) exp_q.push_back(FIL);
      if (wen && sof) begin mq.push_back(wd); m_stream = 1'b1; end
    end else begin
      pop = req && (mq.size() > 0) && m_stream;
      if (req) begin
        if (pop) exp_q.push_back(mq[0]);
        else begin
          exp_q.push_back(FIL);
          if (m_stream) m_udf = 1'b1;
        end
      end
      acc = wen && (m_stream || sof);
      if (acc && mq.size() == D && !pop) begin acc = 1'b0; m_ovf = 1'b1; end
      if (pop) void'(mq.pop_front());
      if (acc) begin mq.push_back(wd); if (sof) m_stream = 1'b1; end
    end
    @(posedge clk);
    #1;
    if (req) begin
      e = exp_q.pop_front();
      m_last = e;
      if (chk16) chk("data_in16", 32'(data_in16), 32'(e));
    end
    chk("data_in", 32'(data_in), 32'(m_last));
    chk("level", 32'(level), 32'(mq.size()));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full", 32'(full), 32'(mq.size() == D));
    chk("almost_full", 32'(almost_full), 32'(mq.size() >= D - 16));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_udf));
    if (chk16) chk("level16", 32'(level16), 32'(mq.size()));
  endtask

  initial begin
    chk16 = 1'b0;
    do_reset();

    // Basic stream: 8 pixels, SOF on the first, then 8 requests.
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'(i + 1), i == 0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("t1_last_pixel", 32'(data_in), 32'h0008);
    chk("t1_empty", 32'(empty), 32'h1);

    // Mid-frame reset, then writes without SOF are dropped; the request is filled, no underflow.
    cyc(1'b1, 16'h5555, 1'b0, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("t2_fill", 32'(data_in), 32'(FIL));
    chk("t2_level", 32'(level), 32'h0);
    chk("t2_udf", 32'(underflow), 32'h0);

    // Fill to DEPTH, write once more (overflow), then write and read together at full.
    for (int i = 0; i < D; i++) cyc(1'b1, 16'(16'h1000 + i), i == 0, 1'b0, 1'b0);
    cyc(1'b1, 16'hEEEE, 1'b0, 1'b0, 1'b0);
    chk("t3_full", 32'(full), 32'h1);
    chk("t3_ovf", 32'(overflow), 32'h1);
    chk("t3_level", 32'(level), 32'(D));
    cyc(1'b1, 16'h2000, 1'b0, 1'b0, 1'b1);
    chk("t3_rw_level", 32'(level), 32'(D));
    for (int i = 0; i < D; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("t3_tail", 32'(data_in), 32'h2000);
    // Request while empty in STREAM: fill and underflow, cleared by the next vsync rise.
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("t3_udf_fill", 32'(data_in), 32'(FIL));
    chk("t3_udf", 32'(underflow), 32'h1);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("t3_udf_clr", 32'(underflow), 32'h0);
    chk("t3_ovf_clr", 32'(overflow), 32'h0);

    // Level 100, then a vsync rise coinciding with an SOF write of ABCD.
    for (int i = 0; i < 100; i++) cyc(1'b1, 16'(16'h3000 + i), i == 0, 1'b0, 1'b0);
    chk("t4_level100", 32'(level), 32'd100);
    cyc(1'b1, 16'hABCD, 1'b1, 1'b1, 1'b0);
    chk("t4_level1", 32'(level), 32'd1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("t4_abcd", 32'(data_in), 32'hABCD);

    // Wrap: flush with a request in the edge cycle, then stream 40 pixels through both depths.
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
    chk16 = 1'b1;
    chk("t5_edge_fill16", 32'(data_in16), 32'(FIL));
    for (int i = 0; i < 40; i++)
      cyc(1'b1, 16'(16'h4000 + i), i == 0, 1'b1,
          (mq.size() >= 4) || (mq.size() >= 2 && (i % 3) == 0));
    while (mq.size() > 0) cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
    chk("t5_last16", 32'(data_in16), 32'h4027);
    chk("t5_udf16", 32'(udf16), 32'h0);
    chk("t5_ovf16", 32'(ovf16), 32'h0);
`ifdef LCD_PIXEL_FIFO_STAT_EN
    chk("t5_ovf_cnt16", 32'(ovf_cnt16), 32'h0);
    chk("t5_udf_cnt16", 32'(udf_cnt16), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
